// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the standard-slave RAM wrapper.
// Default bus widths and word/address types.
package wb_pkg;

    localparam int ADR_WIDTH = 16;
    localparam int DAT_WIDTH = 16;

    typedef logic [ADR_WIDTH-1:0] adr_t;
    typedef logic [DAT_WIDTH-1:0] dat_t;

endpackage

// File: rtl/if_wb.sv
// Point-to-point Wishbone B4 link; names from the slave's point of view.
// dat_i carries write data, dat_o carries read data.
interface if_wb
    import wb_pkg::*;
#(
    parameter int adr_width = ADR_WIDTH,
    parameter int dat_width = DAT_WIDTH
) (
    input logic clk,
    input logic rst
);

    logic [adr_width-1:0] adr;
    logic [dat_width-1:0] dat_i;
    logic [dat_width-1:0] dat_o;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;
    logic                 stall;

    modport master (
        input  clk, rst, dat_o, ack, stall,
        output adr, dat_i, we, cyc, stb
    );

    modport slave (
        input  clk, rst, adr, dat_i, we, cyc, stb,
        output dat_o, ack, stall
    );

endinterface

// File: rtl/wb_slave_standard.sv
// Classic-mode Wishbone RAM slave: registered single-cycle ACK,
// read data valid in the ACK cycle, full-word accesses only.
module wb_slave_standard
    import wb_pkg::*;
#(
    parameter int adr_width = ADR_WIDTH,
    parameter int dat_width = DAT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [adr_width-1:0] i_adr,
    input  logic [dat_width-1:0] i_dat,
    input  logic                 i_we,
    input  logic                 i_cyc,
    input  logic                 i_stb,
    output logic [dat_width-1:0] o_dat,
    output logic                 o_ack
);

    localparam int DEPTH = 2 ** adr_width;

    logic [dat_width-1:0] r_mem [DEPTH];
    logic [dat_width-1:0] r_dat;
    logic                 r_ack;
    logic                 w_req;

    // Masking with r_ack stops a held strobe from being acked twice.
    assign w_req = i_cyc & i_stb & ~r_ack;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            if (w_req && !i_we) begin
                r_dat <= r_mem[i_adr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_req && i_we) begin
            r_mem[i_adr] <= i_dat;
        end
    end

    assign o_dat = r_dat;
    assign o_ack = r_ack;

endmodule

// File: rtl/wb_slave_standard_wrapper.sv
// Presents the classic RAM slave to a pipelined-mode master by
// deriving STALL from the slave's own ACK.
module wb_slave_standard_wrapper
    import wb_pkg::*;
#(
    parameter int adr_width = ADR_WIDTH,
    parameter int dat_width = DAT_WIDTH
) (
    if_wb.slave wb
);

    logic w_ack;

    wb_slave_standard #(
        .adr_width (adr_width),
        .dat_width (dat_width)
    ) u_core (
        .i_clk   (wb.clk),
        .i_rst_n (wb.rst),
        .i_adr   (wb.adr),
        .i_dat   (wb.dat_i),
        .i_we    (wb.we),
        .i_cyc   (wb.cyc),
        .i_stb   (wb.stb),
        .o_dat   (wb.dat_o),
        .o_ack   (w_ack)
    );

    // The ACK cycle is the only cycle a pending request is accepted.
    assign wb.ack   = w_ack;
    assign wb.stall = wb.cyc & wb.stb & ~w_ack;

endmodule

// File: tb/tb_wb_slave_standard_wrapper.sv
// Directed bench for the pipelined wrapper around the classic RAM slave.
// Inputs change 1ns after a rising edge; outputs sampled away from it.
module tb_wb_slave_standard_wrapper;
    import wb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    if_wb #(.adr_width(ADR_WIDTH), .dat_width(DAT_WIDTH)) wb (
        .clk (clk),
        .rst (rst)
    );

    wb_slave_standard_wrapper #(
        .adr_width (ADR_WIDTH),
        .dat_width (DAT_WIDTH)
    ) dut (
        .wb (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        wb.cyc   = 1'b0;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.adr   = '0;
        wb.dat_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (wb.ack !== 1'b0 || wb.stall !== 1'b0 || wb.dat_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_hold ack=%b stall=%b dat_o=%h want 0/0/0",
                     wb.ack, wb.stall, wb.dat_o);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (wb.ack !== 1'b0 || wb.stall !== 1'b0 || wb.dat_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_idle ack=%b stall=%b dat_o=%h want 0/0/0",
                     wb.ack, wb.stall, wb.dat_o);
        end
    endtask

    // One transfer, cyc dropped right after its ACK; checks the
    // request-cycle stall, the ACK cycle and the pulse ending.
    task automatic single_xfer(input adr_t a, input dat_t d, input logic w,
                               input dat_t exp_rd, input string tag);
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w; wb.adr = a; wb.dat_i = d;
        @(negedge clk);
        n_checks++;
        if (wb.stall !== 1'b1 || wb.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_req adr=%0d stall=%b ack=%b want 1/0",
                     tag, a, wb.stall, wb.ack);
        end
        @(posedge clk); #1;
        n_checks++;
        if (wb.ack !== 1'b1 || wb.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ack adr=%0d ack=%b stall=%b want 1/0",
                     tag, a, wb.ack, wb.stall);
        end
        if (!w) begin
            n_checks++;
            if (wb.dat_o !== exp_rd) begin
                n_fail++;
                $display("FAIL %s_data adr=%0d dat_o=%0d want %0d",
                         tag, a, wb.dat_o, exp_rd);
            end
        end
        idle_bus();
        @(posedge clk); #1;
        n_checks++;
        if (wb.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse adr=%0d ack=%b want 0", tag, a, wb.ack);
        end
    endtask

    task automatic test_single_writes();
        for (int i = 1; i <= 10; i++)
            single_xfer(adr_t'(i), dat_t'(100 + i), 1'b1, '0, "wr");
    endtask

    task automatic test_single_reads();
        for (int i = 1; i <= 10; i++)
            single_xfer(adr_t'(i), '0, 1'b0, dat_t'(100 + i), "rd");
    endtask

    // Held cyc/stb burst over adr 11..20; master advances in each ACK cycle.
    task automatic burst(input logic w, input string tag);
        int idx;
        int last_cyc;
        int n_ack;
        idx = 0;
        last_cyc = -1;
        n_ack = 0;
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = w;
        wb.adr = adr_t'(11); wb.dat_i = dat_t'(211);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (wb.ack === 1'b1) begin
                n_ack++;
                if (!w && idx < 10) begin
                    n_checks++;
                    if (wb.dat_o !== dat_t'(211 + idx)) begin
                        n_fail++;
                        $display("FAIL %s_data idx=%0d dat_o=%0d want %0d",
                                 tag, idx, wb.dat_o, 211 + idx);
                    end
                end
                if (last_cyc >= 0) begin
                    n_checks++;
                    if (c - last_cyc != 2) begin
                        n_fail++;
                        $display("FAIL %s_spacing idx=%0d gap=%0d want 2",
                                 tag, idx, c - last_cyc);
                    end
                end
                last_cyc = c;
                idx++;
                if (idx < 10) begin
                    wb.adr   = adr_t'(11 + idx);
                    wb.dat_i = dat_t'(211 + idx);
                end else begin
                    wb.stb = 1'b0;
                end
            end else if (idx == 10 && wb.cyc) begin
                wb.cyc = 1'b0;
            end
        end
        idle_bus();
        n_checks++;
        if (n_ack != 10) begin
            n_fail++;
            $display("FAIL %s_ack_count acks=%0d want 10", tag, n_ack);
        end
    endtask

    task automatic test_back_to_back();
        burst(1'b1, "bwr");
        burst(1'b0, "brd");
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        wb.cyc = 1'b0; wb.stb = 1'b1; wb.we = 1'b1;
        wb.adr = adr_t'(5); wb.dat_i = 16'hDEAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (wb.ack !== 1'b0 || wb.stall !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_nocyc c=%0d ack=%b stall=%b want 0/0",
                         c, wb.ack, wb.stall);
            end
        end
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wb.ack !== 1'b0 || wb.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_nostb ack=%b stall=%b want 0/0",
                     wb.ack, wb.stall);
        end
        idle_bus();
        single_xfer(adr_t'(5), '0, 1'b0, dat_t'(105), "abrd");
    endtask

    task automatic test_addr_bounds();
        single_xfer(adr_t'(0), 16'h1234, 1'b1, '0, "lo_wr");
        single_xfer(adr_t'(16'hFFFF), 16'hBEEF, 1'b1, '0, "hi_wr");
        single_xfer(adr_t'(16'h8001), 16'h5A5A, 1'b1, '0, "alias_wr");
        single_xfer(adr_t'(0), '0, 1'b0, 16'h1234, "lo_rd");
        single_xfer(adr_t'(16'hFFFF), '0, 1'b0, 16'hBEEF, "hi_rd");
        single_xfer(adr_t'(1), '0, 1'b0, dat_t'(101), "alias_rd");
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = adr_t'(16'hFFFF);
        @(posedge clk); #1;
        n_checks++;
        if (wb.ack !== 1'b1 || wb.dat_o !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL arst_pre ack=%b dat_o=%h want 1/beef",
                     wb.ack, wb.dat_o);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (wb.ack !== 1'b0 || wb.dat_o !== 16'h0) begin
            n_fail++;
            $display("FAIL arst_clear ack=%b dat_o=%h want 0/0",
                     wb.ack, wb.dat_o);
        end
        idle_bus();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wb.stall !== 1'b0 || wb.ack !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_idle ack=%b stall=%b want 0/0",
                     wb.ack, wb.stall);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_writes();
        test_single_reads();
        test_back_to_back();
        test_abort();
        test_addr_bounds();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
